// File: rtl/instr_fetch_if.sv
// Instruction fetch bus: program ROM address/data, decoded-stage handshake
// and the redirect (jump) request. The fetch unit is the master.
interface instr_fetch_if;
  logic [7:0] rom_address;
  logic [7:0] rom_data;
  logic [7:0] instr;
  logic [7:0] instr_pc;
  logic       instr_valid;
  logic       instr_ready;
  logic       jump_en;
  logic [7:0] jump_addr;

  modport master (
    output rom_address, instr, instr_pc, instr_valid,
    input  rom_data, instr_ready, jump_en, jump_addr
  );

  modport slave (
    input  rom_address, instr, instr_pc, instr_valid,
    output rom_data, instr_ready, jump_en, jump_addr
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues sequential addresses to a synchronous ROM,
// tracks two in-flight fetch stages and queues returned bytes (with their
// address) in a small FIFO toward the consumer. A jump squashes everything
// queued or in flight and restarts fetching at the target address.
module instr_fetch #(
  parameter int FIFO_DEPTH = 4
) (
  input logic           clk,
  input logic           rst,
  instr_fetch_if.master bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic       valid;
    logic [7:0] addr;
  } stage_t;

  typedef struct packed {
    logic [7:0] pc;
    logic [7:0] data;
  } entry_t;

  logic [7:0]       pc;
  stage_t           s1;
  stage_t           s2;
  entry_t           fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   occupancy;
  logic             head_valid;
  entry_t           head;
  logic             can_issue;
  logic             push;
  logic             pop;

  // Every issued fetch reserves a queue slot until its byte is written, so
  // counting in-flight stages here is what keeps the FIFO from overflowing.
  assign occupancy  = (CNT_W+1)'(count) + (CNT_W+1)'(s1.valid) + (CNT_W+1)'(s2.valid);
  assign head_valid = (count != '0);
  assign head       = fifo_mem[rd_ptr];

  // Issue/push/pop decisions for this cycle; a jump overrides issue and push
  always_comb begin
    // NOTE: every always_comb output is given a default first so no path leaves it unassigned and infers a latch.
    can_issue = 1'b0;
    push      = 1'b0;
    pop       = head_valid && bus.instr_ready;
    if (!bus.jump_en) begin
      can_issue = (occupancy < (CNT_W+1)'(FIFO_DEPTH));
      push      = s2.valid;
    end
  end

  // Fetch pipeline: PC, ROM address and the two in-flight stages
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      pc              <= 8'h00;
      bus.rom_address <= 8'h00;
      s1              <= '0;
      s2              <= '0;
    end else if (bus.jump_en) begin
      bus.rom_address <= bus.jump_addr;
      s1              <= '{valid: 1'b1, addr: bus.jump_addr};
      s2              <= '0;
      pc              <= bus.jump_addr + 8'd1;
    end else begin
      s2 <= s1;
      if (can_issue) begin
        bus.rom_address <= pc;
        s1              <= '{valid: 1'b1, addr: pc};
        pc              <= pc + 8'd1;
      end else begin
        s1.valid <= 1'b0;
      end
    end
  end

  // Queue storage write: byte returned by the ROM for the fetch now in S2
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; count alone says which entries are meaningful.
    if (push) begin
      fifo_mem[wr_ptr] <= '{pc: s2.addr, data: bus.rom_data};
    end
  end

  // Queue pointers and occupancy count; a jump empties the queue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.jump_en) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Consumer view of the queue head; zero whenever the queue is empty
  assign bus.instr_valid = head_valid;
  assign bus.instr       = head_valid ? head.data : 8'h00;
  assign bus.instr_pc    = head_valid ? head.pc : 8'h00;

  // The issue rule must never let a byte arrive at a full queue
  no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && count == CNT_W'(FIFO_DEPTH)));

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, instruction queue entries; SHALL be a power of two and at least 3.
REQ-002 Port: CLK  in  1  single clock; all state changes on its rising edge.
REQ-003 Port: RESET  in  1  asynchronous, active-high reset.
REQ-004 Port: ROM_ADDRESS  out  8  registered address driven to the program ROM ADDR port.
REQ-005 Port: ROM_DATA  in  8  ROM DATA; the value in cycle n+1 is mem[ROM_ADDRESS of cycle n].
REQ-006 Port: INSTR  out  8  instruction byte at the queue head.
REQ-007 Port: INSTR_PC  out  8  ROM address the INSTR byte was fetched from.
REQ-008 Port: INSTR_VALID  out  1  queue head valid.
REQ-009 Port: INSTR_READY  in  1  consumer accepts the head this cycle.
REQ-010 Port: JUMP_EN  in  1  one-cycle redirect request.
REQ-011 Port: JUMP_ADDR  in  8  redirect target, sampled when JUMP_EN=1.

Function
REQ-012 Internal state SHALL be:
- PC (next fetch address, 8 bit).
- Two in-flight stages S1/S2, each holding valid + address.
- FIFO of FIFO_DEPTH entries of {pc, byte}, with a count.
REQ-013 Issue: at an edge where count + S1.valid + S2.valid < FIFO_DEPTH and JUMP_EN=0:
- ROM_ADDRESS<=PC, S1<={1,PC}, PC<=PC+1.
- Otherwise S1.valid<=0, and ROM_ADDRESS and PC SHALL hold.
REQ-014 PC increment SHALL wrap modulo 256: 0xFF -> 0x00, with no flag and no stall.
REQ-015 Each edge, S2<=S1.
- When S2.valid=1, ROM_DATA SHALL be written to the FIFO tail with pc=S2.address.
- Capture latency SHALL be exactly 3 edges from the issue edge to FIFO write.
REQ-016 The head transfers when INSTR_VALID=1 and INSTR_READY=1 at an edge; INSTR/INSTR_PC SHALL then advance to the next entry.
REQ-017 Simultaneous push and pop SHALL leave count unchanged; FIFO data order is strict first-in, first-out.
REQ-018 The issue rule SHALL make FIFO overflow impossible; push while count=FIFO_DEPTH is a design error and SHALL be asserted against in simulation.
REQ-019 When INSTR_VALID=0, INSTR_READY SHALL be ignored (no pop on empty).
REQ-020 INSTR_VALID=1 iff count>0. INSTR/INSTR_PC SHALL be stable while INSTR_VALID=1 and INSTR_READY=0.
REQ-021 With INSTR_READY held at 1 and no jumps, throughput SHALL be one instruction per cycle after the initial latency.
REQ-022 JUMP_EN=1 at an edge SHALL:
- Clear the FIFO (count<=0) and clear S1/S2 valid; ROM_DATA arriving for squashed fetches SHALL be discarded.
- Issue JUMP_ADDR: ROM_ADDRESS<=JUMP_ADDR, S1<={1,JUMP_ADDR}, PC<=JUMP_ADDR+1.
REQ-023 A pop handshake in the same cycle as JUMP_EN SHALL count as delivered; the jump SHALL override any push or issue in that edge.
REQ-024 mem[JUMP_ADDR] SHALL appear with INSTR_VALID=1 in the third cycle after the jump edge, if no further jump occurs.
REQ-025 JUMP_ADDR=0xFF SHALL fetch 0xFF and then 0x00 (wrap).
REQ-026 Back-to-back JUMP_EN cycles SHALL each fully redirect; only the last target's stream SHALL be delivered.

Reset
REQ-027 While RESET=1, independent of CLK, the following SHALL hold:
- PC=0x00, ROM_ADDRESS=0x00.
- S1/S2 valid=0, count=0.
- INSTR=0x00, INSTR_PC=0x00, INSTR_VALID=0.
REQ-028 Reset asserted mid-operation SHALL discard all queued and in-flight fetches immediately.
REQ-029 The first issue SHALL occur at the first edge after RESET deasserts (address 0x00).
- INSTR_VALID SHALL rise after the third edge with INSTR=mem[0x00], INSTR_PC=0x00.

Verification
REQ-030 ROM preloaded mem[i]=i^0xA5, READY=1, release reset -> third cycle INSTR=0xA5/PC=0x00, then 0xA4/0x01, 0xA7/0x02 on consecutive cycles.
REQ-031 READY=0 for 10 cycles after reset -> count stalls at 4, ROM_ADDRESS holds at 0x03, INSTR stays 0xA5/0x00; READY=1 -> PCs 0x00..0x07 delivered in order, none lost or duplicated.
REQ-032 JUMP_EN=1 with JUMP_ADDR=0x40 while queue holds 0x05..0x07 -> INSTR_VALID=0 for two cycles, third cycle INSTR_PC=0x40, INSTR=0xE5; no 0x05..0x09 bytes ever appear afterward.
REQ-033 JUMP_ADDR=0xFE, READY=1 -> delivered PCs 0xFE, 0xFF, 0x00, 0x01 consecutively.
REQ-034 JUMP_EN pulses at 0x10 then 0x20 on consecutive cycles -> first delivered PC is 0x20.
REQ-035 RESET pulsed for 3 ns mid-stream between clock edges -> all outputs zero immediately, restart sequence identical to REQ-030.
